// File: rtl/alu_unit_if.sv
// Purpose : RS->ALU issue bus plus ALU CDB broadcast, bundled for port use.
// Ports   : exe_* issue fields driven by the reservation station (master),
//           alu_* broadcast fields driven by the ALU (slave).
interface alu_unit_if #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
);
  logic                exe_valid;
  logic [6:0]          exe_opcode;
  logic [2:0]          exe_func3;
  logic                exe_func1;
  logic [DATA_W-1:0]   exe_data1;
  logic [DATA_W-1:0]   exe_data2;
  logic [DATA_W-1:0]   exe_imm;
  logic [DATA_W-1:0]   exe_off;
  logic [DATA_W-1:0]   exe_pc;
  logic [ROB_ID_W-1:0] exe_rob_target;

  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_jump;
  logic [DATA_W-1:0]   alu_target;

  modport master (
    output exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_off, exe_pc, exe_rob_target,
    input  alu_valid, alu_rob_id, alu_data, alu_jump, alu_target
  );

  modport slave (
    input  exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_off, exe_pc, exe_rob_target,
    output alu_valid, alu_rob_id, alu_data, alu_jump, alu_target
  );
endinterface

// File: rtl/alu_unit.sv
// Purpose : RV32I integer/control execute stage; broadcasts result and branch
//           outcome on the ALU CDB.
// Latency : 1 cycle, one instruction per cycle. Backpressure: none; rdy=0
//           freezes all outputs, rst/rollback clear them.
// Ports   : clk, rst (sync, active-high), rdy (global enable), rollback
//           (flush), bus (alu_unit_if.slave: exe_* in, alu_* out).
module alu_unit #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rollback,
  alu_unit_if.slave  bus
);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [DATA_W-1:0]   w_a, w_b, w_pc4, w_alu, w_res, w_tgt, w_jalr;
  logic                w_jump, w_cond, w_slt, w_sltu, w_blt, w_bltu;

  logic                r_valid;
  logic [ROB_ID_W-1:0] r_rob_id;
  logic [DATA_W-1:0]   r_data;
  logic                r_jump;
  logic [DATA_W-1:0]   r_target;

  always_comb begin
    w_a    = bus.exe_data1;
    // OP-IMM takes its second operand from the immediate
    w_b    = (bus.exe_opcode == OP_REG) ? bus.exe_data2 : bus.exe_imm;
    w_pc4  = bus.exe_pc + DATA_W'(4);
    w_jalr = (bus.exe_data1 + bus.exe_imm) & ~DATA_W'(1);
    w_slt  = $signed(w_a) < $signed(w_b);
    w_sltu = w_a < w_b;
    w_blt  = $signed(bus.exe_data1) < $signed(bus.exe_data2);
    w_bltu = bus.exe_data1 < bus.exe_data2;

    w_alu = '0;
    case (bus.exe_func3)
      3'b000: w_alu = (bus.exe_opcode == OP_REG && bus.exe_func1) ? (w_a - w_b) : (w_a + w_b);
      3'b001: w_alu = w_a << w_b[4:0];
      3'b010: w_alu = {{(DATA_W-1){1'b0}}, w_slt};
      3'b011: w_alu = {{(DATA_W-1){1'b0}}, w_sltu};
      3'b100: w_alu = w_a ^ w_b;
      3'b101: w_alu = bus.exe_func1 ? DATA_W'($signed(w_a) >>> w_b[4:0]) : (w_a >> w_b[4:0]);
      3'b110: w_alu = w_a | w_b;
      default: w_alu = w_a & w_b;
    endcase

    w_cond = 1'b0;
    case (bus.exe_func3)
      3'b000:  w_cond = bus.exe_data1 == bus.exe_data2;
      3'b001:  w_cond = bus.exe_data1 != bus.exe_data2;
      3'b100:  w_cond = w_blt;
      3'b101:  w_cond = ~w_blt;
      3'b110:  w_cond = w_bltu;
      3'b111:  w_cond = ~w_bltu;
      default: w_cond = 1'b0;
    endcase

    // Unknown opcodes still broadcast (data=0, fall-through) so the ROB retires them
    w_res  = '0;
    w_jump = 1'b0;
    w_tgt  = w_pc4;
    case (bus.exe_opcode)
      OP_REG, OP_IMM: w_res = w_alu;
      OP_LUI:         w_res = bus.exe_imm;
      OP_AUI:         w_res = bus.exe_pc + bus.exe_imm;
      OP_JAL: begin
        w_res  = w_pc4;
        w_jump = 1'b1;
        w_tgt  = bus.exe_pc + bus.exe_off;
      end
      OP_JLR: begin
        w_res  = w_pc4;
        w_jump = 1'b1;
        w_tgt  = w_jalr;
      end
      OP_BR: begin
        w_jump = w_cond;
        w_tgt  = w_cond ? (bus.exe_pc + bus.exe_off) : w_pc4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      r_valid  <= 1'b0;
      r_rob_id <= '0;
      r_data   <= '0;
      r_jump   <= 1'b0;
      r_target <= '0;
    end else if (rdy) begin
      r_valid <= bus.exe_valid;
      if (bus.exe_valid) begin
        r_rob_id <= bus.exe_rob_target;
        r_data   <= w_res;
        r_jump   <= w_jump;
        r_target <= w_tgt;
      end
    end
  end

  assign bus.alu_valid  = r_valid;
  assign bus.alu_rob_id = r_rob_id;
  assign bus.alu_data   = r_data;
  assign bus.alu_jump   = r_jump;
  assign bus.alu_target = r_target;
endmodule

// File: tb/tb_alu_unit.sv
// Purpose : self-checking bench for alu_unit; expected CDB results are queued
//           when an instruction is issued and compared when it is broadcast.
// Ports   : none (top level); drives alu_unit through alu_unit_if.
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_unit_if #(.DATA_W(32), .ROB_ID_W(4)) bus ();

  alu_unit #(.DATA_W(32), .ROB_ID_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f1;
    logic [31:0] d1, d2, imm, off, pc;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jump;
    logic [31:0] tgt;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f1,
                              logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                              logic [31:0] off, logic [31:0] pc, logic [3:0] tag,
                              logic [31:0] data, logic jump, logic [31:0] tgt);
    vec_t v;
    v.op = op; v.f3 = f3; v.f1 = f1; v.d1 = d1; v.d2 = d2; v.imm = imm;
    v.off = off; v.pc = pc; v.tag = tag; v.data = data; v.jump = jump; v.tgt = tgt;
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one issue; queues its expected broadcast only when it will be accepted
  task automatic drive(input vec_t v, input logic vld);
    exp_t e;
    bus.exe_valid      = vld;
    bus.exe_opcode     = v.op;
    bus.exe_func3      = v.f3;
    bus.exe_func1      = v.f1;
    bus.exe_data1      = v.d1;
    bus.exe_data2      = v.d2;
    bus.exe_imm        = v.imm;
    bus.exe_off        = v.off;
    bus.exe_pc         = v.pc;
    bus.exe_rob_target = v.tag;
    if (vld && rdy && !rst && !rollback) begin
      e.tag = v.tag; e.data = v.data; e.jump = v.jump; e.tgt = v.tgt;
      sb.push_back(e);
    end
  endtask

  task automatic check_out(input string nm, input exp_t e);
    check_val({nm, ".valid"},  {31'b0, bus.alu_valid}, 32'd1);
    check_val({nm, ".rob_id"}, {28'b0, bus.alu_rob_id}, {28'b0, e.tag});
    check_val({nm, ".data"},   bus.alu_data, e.data);
    check_val({nm, ".jump"},   {31'b0, bus.alu_jump}, {31'b0, e.jump});
    check_val({nm, ".target"}, bus.alu_target, e.tgt);
  endtask

  // One clock; then compare against the scoreboard head, or expect no broadcast
  task automatic cyc(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_out(nm, e);
    end else begin
      check_val({nm, ".idle_valid"}, {31'b0, bus.alu_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    exp_t held;
    idle = mk(7'h00, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4'd0, 0, 1'b0, 0);

    // OP, OP-IMM, shifts, compares, logic
    vecs.push_back(mk(7'b0110011, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h0, 4'd5, 32'h80000000, 1'b0, 32'h4));
    vecs.push_back(mk(7'b0010011, 3'b000, 1'b1, 32'd10, 32'd99, 32'd3, 0, 32'h10, 4'd1, 32'd13, 1'b0, 32'h14));
    vecs.push_back(mk(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd77, 0, 32'h20, 4'd2, 32'd7, 1'b0, 32'h24));
    vecs.push_back(mk(7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd4, 0, 0, 32'h30, 4'd3, 32'hF8000000, 1'b0, 32'h34));
    vecs.push_back(mk(7'b0010011, 3'b101, 1'b1, 32'h80000000, 0, 32'h404, 0, 32'h34, 4'd4, 32'hF8000000, 1'b0, 32'h38));
    vecs.push_back(mk(7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'd4, 0, 0, 32'h38, 4'd6, 32'h08000000, 1'b0, 32'h3C));
    vecs.push_back(mk(7'b0110011, 3'b011, 1'b0, 32'h1, 32'hFFFFFFFF, 0, 0, 32'h3C, 4'd7, 32'd1, 1'b0, 32'h40));
    vecs.push_back(mk(7'b0110011, 3'b010, 1'b0, 32'h1, 32'hFFFFFFFF, 0, 0, 32'h40, 4'd8, 32'd0, 1'b0, 32'h44));
    vecs.push_back(mk(7'b0110011, 3'b001, 1'b0, 32'h1, 32'd31, 0, 0, 32'h44, 4'd9, 32'h80000000, 1'b0, 32'h48));
    vecs.push_back(mk(7'b0010011, 3'b100, 1'b0, 32'hF0F0F0F0, 0, 32'hFFFFFFFF, 0, 32'h48, 4'd10, 32'h0F0F0F0F, 1'b0, 32'h4C));
    vecs.push_back(mk(7'b0110011, 3'b111, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 32'h4C, 4'd11, 32'h0F000F00, 1'b0, 32'h50));
    // Branches and jumps
    vecs.push_back(mk(7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h1, 0, 32'h20, 32'h100, 4'd12, 32'h0, 1'b1, 32'h120));
    vecs.push_back(mk(7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h1, 0, 32'h20, 32'h100, 4'd13, 32'h0, 1'b0, 32'h104));
    vecs.push_back(mk(7'b1100011, 3'b000, 1'b0, 32'h55, 32'h55, 0, 32'hFFFFFFF8, 32'h200, 4'd14, 32'h0, 1'b1, 32'h1F8));
    vecs.push_back(mk(7'b1100011, 3'b010, 1'b0, 32'h55, 32'h55, 0, 32'h40, 32'h200, 4'd15, 32'h0, 1'b0, 32'h204));
    vecs.push_back(mk(7'b1100111, 3'b000, 1'b0, 32'h1001, 0, 32'd2, 0, 32'h40, 4'd0, 32'h44, 1'b1, 32'h1002));
    vecs.push_back(mk(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 32'hFFFFFFF0, 32'h200, 4'd1, 32'h204, 1'b1, 32'h1F0));
    vecs.push_back(mk(7'b0110111, 3'b000, 1'b0, 0, 0, 32'h12345000, 0, 32'h300, 4'd2, 32'h12345000, 1'b0, 32'h304));
    vecs.push_back(mk(7'b0010111, 3'b000, 1'b0, 0, 0, 32'h2000, 0, 32'h1000, 4'd3, 32'h3000, 1'b0, 32'h1004));
    vecs.push_back(mk(7'b1111111, 3'b000, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8, 32'hFFFFFFFC, 4'd4, 32'h0, 1'b0, 32'h0));

    // Reset state
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    drive(idle, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.valid",  {31'b0, bus.alu_valid}, 32'd0);
    check_val("rst.data",   bus.alu_data, 32'd0);
    check_val("rst.target", bus.alu_target, 32'd0);
    rst = 1'b0;

    // Whole table issued back to back; each broadcast is checked the cycle after issue
    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      cyc($sformatf("vec%0d", i));
    end
    drive(idle, 1'b0);
    cyc("drain");

    // Instruction issued with rollback is dropped and outputs clear
    drive(vecs[0], 1'b1);
    cyc("pre_rb");
    rollback = 1'b1;
    drive(vecs[1], 1'b1);
    cyc("rb");
    check_val("rb.data", bus.alu_data, 32'd0);
    rollback = 1'b0;

    // rdy low mid-stream: outputs freeze for two cycles, then stream resumes
    drive(vecs[3], 1'b1);
    cyc("frz_a");
    held.tag = vecs[3].tag; held.data = vecs[3].data;
    held.jump = vecs[3].jump; held.tgt = vecs[3].tgt;
    rdy = 1'b0;
    drive(vecs[11], 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("frz_hold%0d", k), held);
    end
    rdy = 1'b1;
    drive(vecs[11], 1'b1);
    cyc("frz_resume");
    drive(vecs[15], 1'b1);
    cyc("frz_next");
    drive(idle, 1'b0);
    cyc("frz_idle");

    check_val("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
